// File: rtl/updi_txn_engine.sv
// Host-side UPDI transaction engine: SYNC, opcode, payload with ACK checks, optional read-back.
// Define UPDI_ECHO_STRIP_EN to check and discard the half-duplex echo of every TX byte.
module updi_txn_engine #(
  parameter int unsigned MAX_DATA_SIZE  = 64,
  parameter int unsigned DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
  parameter int unsigned MAX_RX_SIZE    = 64,
  parameter int unsigned RX_ADDR_BITS   = $clog2(MAX_RX_SIZE),
  parameter int unsigned ACK_TIMEOUT    = 1024,
  parameter logic [7:0]  SYNC_BYTE      = 8'h55,
  parameter logic [7:0]  ACK_BYTE       = 8'h40
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               txn_start,
  output logic                               txn_ready,
  input  logic [7:0]                         opcode,
  input  logic [MAX_DATA_SIZE-1:0][7:0]      data,
  input  logic [DATA_ADDR_BITS:0]            data_len,
  input  logic [MAX_DATA_SIZE-1:0]           wait_ack_after,
  input  logic [RX_ADDR_BITS:0]              rx_n_bytes,
  output logic                               txn_done,
  output logic [1:0]                         status,
  output logic [7:0]                         uart_tx_fifo_data,
  output logic                               uart_tx_fifo_wr_en,
  input  logic                               uart_tx_fifo_full,
  input  logic [7:0]                         uart_rx_fifo_data,
  output logic                               uart_rx_fifo_rd_en,
  input  logic                               uart_rx_fifo_empty,
  output logic [7:0]                         out_rx_fifo_data,
  output logic                               out_rx_fifo_wr_en,
  input  logic                               out_rx_fifo_full
);

  localparam int unsigned LenW = DATA_ADDR_BITS + 1;
  localparam int unsigned RxW  = RX_ADDR_BITS + 1;
  localparam int unsigned TmrW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] StsOk      = 2'd0;
  localparam logic [1:0] StsAckErr  = 2'd1;
  localparam logic [1:0] StsTimeout = 2'd2;
`ifdef UPDI_ECHO_STRIP_EN
  localparam logic [1:0] StsEchoErr = 2'd3;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StOpcode,
    StData,
`ifdef UPDI_ECHO_STRIP_EN
    StEcho,
`endif
    StAck,
    StRx,
    StDone
  } state_e;

  state_e                          state_q, state_d;
  logic [7:0]                      opcode_q, opcode_d;
  logic [MAX_DATA_SIZE-1:0][7:0]   data_q, data_d;
  logic [MAX_DATA_SIZE-1:0]        mask_q, mask_d;
  logic [LenW-1:0]                 len_q, len_d;
  logic [LenW-1:0]                 idx_q, idx_d;
  logic [RxW-1:0]                  rx_n_q, rx_n_d;
  logic [RxW-1:0]                  rx_cnt_q, rx_cnt_d;
  logic [TmrW-1:0]                 timer_q, timer_d;
  logic [1:0]                      status_q, status_d;
  logic                            pend_q, pend_d;
  logic                            out_wr_q, out_wr_d;
  logic [7:0]                      out_data_q, out_data_d;
`ifdef UPDI_ECHO_STRIP_EN
  state_e                          ret_q, ret_d;
  logic [7:0]                      echo_q, echo_d;
`endif

  logic       tx_wr;
  logic [7:0] tx_byte;
  state_e     tx_next;
  state_e     rx_or_done;
  logic       rd_en;
  logic       rx_wait;
  logic       sample;

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    data_d     = data_q;
    mask_d     = mask_q;
    len_d      = len_q;
    idx_d      = idx_q;
    rx_n_d     = rx_n_q;
    rx_cnt_d   = rx_cnt_q;
    timer_d    = timer_q;
    status_d   = status_q;
    pend_d     = pend_q;
    out_wr_d   = 1'b0;
    out_data_d = out_data_q;
`ifdef UPDI_ECHO_STRIP_EN
    ret_d      = ret_q;
    echo_d     = echo_q;
`endif
    tx_wr      = 1'b0;
    tx_byte    = 8'h00;
    tx_next    = state_q;
    rd_en      = 1'b0;
    sample     = 1'b0;
    rx_or_done = (rx_n_q != '0) ? StRx : StDone;

    rx_wait = (state_q == StAck) || (state_q == StRx);
`ifdef UPDI_ECHO_STRIP_EN
    if (state_q == StEcho) rx_wait = 1'b1;
`endif

    // Shared pop/timeout handling for every state that waits on an RX byte.
    if (rx_wait) begin
      if (pend_q) begin
        sample  = 1'b1;
        pend_d  = 1'b0;
        timer_d = '0;
      end else if (!(state_q == StRx && out_rx_fifo_full)) begin
        if (!uart_rx_fifo_empty) begin
          rd_en  = 1'b1;
          pend_d = 1'b1;
        end else if (timer_q == TmrW'(ACK_TIMEOUT - 1)) begin
          status_d = StsTimeout;
          state_d  = StDone;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (txn_start) begin
          opcode_d = opcode;
          data_d   = data;
          mask_d   = wait_ack_after;
          len_d    = (data_len > LenW'(MAX_DATA_SIZE)) ? LenW'(MAX_DATA_SIZE) : data_len;
          rx_n_d   = (rx_n_bytes > RxW'(MAX_RX_SIZE)) ? RxW'(MAX_RX_SIZE) : rx_n_bytes;
          idx_d    = '0;
          rx_cnt_d = '0;
          status_d = StsOk;
          state_d  = StSync;
        end
      end
      StSync: begin
        if (!uart_tx_fifo_full) begin
          tx_wr   = 1'b1;
          tx_byte = SYNC_BYTE;
          tx_next = StOpcode;
        end
      end
      StOpcode: begin
        if (!uart_tx_fifo_full) begin
          tx_wr   = 1'b1;
          tx_byte = opcode_q;
          tx_next = (len_q == '0) ? rx_or_done : StData;
        end
      end
      StData: begin
        if (!uart_tx_fifo_full) begin
          tx_wr   = 1'b1;
          tx_byte = data_q[idx_q[DATA_ADDR_BITS-1:0]];
          idx_d   = idx_q + LenW'(1);
          if (mask_q[idx_q[DATA_ADDR_BITS-1:0]]) tx_next = StAck;
          else if (idx_d == len_q)               tx_next = rx_or_done;
          else                                   tx_next = StData;
        end
      end
`ifdef UPDI_ECHO_STRIP_EN
      StEcho: begin
        if (sample) begin
          if (uart_rx_fifo_data != echo_q) begin
            status_d = StsEchoErr;
            state_d  = StDone;
          end else begin
            state_d = ret_q;
          end
        end
      end
`endif
      StAck: begin
        if (sample) begin
          if (uart_rx_fifo_data != ACK_BYTE) begin
            status_d = StsAckErr;
            state_d  = StDone;
          end else begin
            state_d = (idx_q == len_q) ? rx_or_done : StData;
          end
        end
      end
      StRx: begin
        if (sample) begin
          out_wr_d   = 1'b1;
          out_data_d = uart_rx_fifo_data;
          rx_cnt_d   = rx_cnt_q + RxW'(1);
          if (rx_cnt_d == rx_n_q) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (tx_wr) begin
`ifdef UPDI_ECHO_STRIP_EN
      state_d = StEcho;
      ret_d   = tx_next;
      echo_d  = tx_byte;
`else
      state_d = tx_next;
`endif
    end

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      opcode_q   <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      rx_n_q     <= '0;
      rx_cnt_q   <= '0;
      timer_q    <= '0;
      status_q   <= StsOk;
      pend_q     <= 1'b0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
`ifdef UPDI_ECHO_STRIP_EN
      ret_q      <= StIdle;
      echo_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      rx_n_q     <= rx_n_d;
      rx_cnt_q   <= rx_cnt_d;
      timer_q    <= timer_d;
      status_q   <= status_d;
      pend_q     <= pend_d;
      out_wr_q   <= out_wr_d;
      out_data_q <= out_data_d;
`ifdef UPDI_ECHO_STRIP_EN
      ret_q      <= ret_d;
      echo_q     <= echo_d;
`endif
    end
  end

  assign txn_ready          = (state_q == StIdle);
  assign txn_done           = (state_q == StDone);
  assign status             = status_q;
  assign uart_tx_fifo_wr_en = tx_wr;
  assign uart_tx_fifo_data  = tx_byte;
  assign uart_rx_fifo_rd_en = rd_en;
  assign out_rx_fifo_wr_en  = out_wr_q;
  assign out_rx_fifo_data   = out_data_q;

endmodule
